// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder.
// No logic; latency and backpressure do not apply.
// Imported by the responder top.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_PREAMBLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;
    localparam logic [4:0] REG_ADV  = 5'd4;

    localparam logic [15:0] STAT_BASE = 16'h7809;

    localparam int PREAMBLE_LEN = 32;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronizes MDC/MDIO into aclk and flags MDC rising/falling edges.
// Latency: edge flag appears 3 aclk cycles after the pin changes.
// Backpressure: none; free-running sampler.
module mdio_edge_sync (
    input  logic aclk,
    input  logic rst,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);

    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    always_ff @(posedge aclk) begin
        if (rst) begin
            mdc_q  <= 3'b111;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc_i};
            mdio_q <= {mdio_q[0], mdio_i};
        end
    end

    // mdc_q[1] is the second synchronizer stage, mdc_q[2] the edge-detect history.
    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdc_fall = ~mdc_q[1] & mdc_q[2];
    assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder with a small register file, oversampling MDC in aclk.
// Latency: line drive updates 4 aclk after an MDC fall; writes commit 1 cycle after the D0 rise flag.
// Backpressure: none; MDC high/low phases must each be at least 6 aclk cycles.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] CTRL_DEFAULT = 16'h3100,
    parameter logic [15:0] ADV_DEFAULT  = 16'h01E1
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic [15:0] adv_reg,
    output logic        wr_pulse,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    logic mdc_rise;
    logic mdc_fall;
    logic mdio_s;

    mdio_edge_sync u_sync (
        .aclk     (aclk),
        .rst      (rst),
        .mdc_i    (mdc_i),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_s   (mdio_s)
    );

    state_t      state;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic [1:0]  op_q;
    logic [4:0]  phy_q;
    logic [4:0]  reg_q;
    logic        rd_act;
    logic        wr_act;
    logic [15:0] tx_q;
    logic [15:0] rx_q;
    logic [15:0] rd_word;
    logic [15:0] wr_word;

    assign wr_word = {rx_q[14:0], mdio_s};

    always_comb begin
        rd_word = 16'h0000;
        case (reg_q)
            REG_CTRL: rd_word = {1'b0, ctrl_reg[14:0]};
            REG_STAT: rd_word = {STAT_BASE[15:3], link_up, STAT_BASE[1:0]};
            REG_ID1:  rd_word = PHY_ID1;
            REG_ID2:  rd_word = PHY_ID2;
            REG_ADV:  rd_word = adv_reg;
            default:  rd_word = 16'h0000;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state    <= ST_PREAMBLE;
            pre_cnt  <= 6'd0;
            bit_cnt  <= 4'd0;
            op_q     <= 2'b00;
            phy_q    <= 5'd0;
            reg_q    <= 5'd0;
            rd_act   <= 1'b0;
            wr_act   <= 1'b0;
            tx_q     <= 16'h0000;
            rx_q     <= 16'h0000;
            mdio_o   <= 1'b0;
            mdio_t   <= 1'b1;
            wr_pulse <= 1'b0;
            wr_addr  <= 5'd0;
            wr_data  <= 16'h0000;
            ctrl_reg <= CTRL_DEFAULT;
            adv_reg  <= ADV_DEFAULT;
        end else begin
            wr_pulse <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    ST_PREAMBLE: begin
                        if (mdio_s) begin
                            if (pre_cnt != 6'h3F) pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_cnt >= 6'(PREAMBLE_LEN)) begin
                            state   <= ST_START;
                            pre_cnt <= 6'd0;
                        end else begin
                            pre_cnt <= 6'd0;
                        end
                    end
                    ST_START: begin
                        bit_cnt <= 4'd0;
                        pre_cnt <= 6'd0;
                        state   <= mdio_s ? ST_OP : ST_PREAMBLE;
                    end
                    ST_OP: begin
                        op_q <= {op_q[0], mdio_s};
                        if (bit_cnt == 4'd1) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_PHYAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PHYAD: begin
                        phy_q <= {phy_q[3:0], mdio_s};
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_REGAD: begin
                        reg_q <= {reg_q[3:0], mdio_s};
                        if (bit_cnt == 4'd4) begin
                            // phy_q and op_q are complete here; decide whether this frame is ours.
                            bit_cnt <= 4'd0;
                            state   <= ST_TA;
                            rd_act  <= (op_q == OP_READ)  && (phy_q == PHY_ADDR);
                            wr_act  <= (op_q == OP_WRITE) && (phy_q == PHY_ADDR);
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_TA: begin
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            if (rd_act) tx_q <= rd_word;
                        end else begin
                            bit_cnt <= 4'd0;
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        rx_q <= wr_word;
                        if (bit_cnt == 4'd15) begin
                            bit_cnt <= 4'd0;
                            pre_cnt <= 6'd0;
                            state   <= ST_PREAMBLE;
                            rd_act  <= 1'b0;
                            wr_act  <= 1'b0;
                            if (wr_act) begin
                                wr_pulse <= 1'b1;
                                wr_addr  <= reg_q;
                                wr_data  <= wr_word;
                                if (reg_q == REG_CTRL) begin
                                    if (wr_word[15]) begin
                                        ctrl_reg <= CTRL_DEFAULT;
                                        adv_reg  <= ADV_DEFAULT;
                                    end else begin
                                        ctrl_reg <= wr_word;
                                    end
                                end else if (reg_q == REG_ADV) begin
                                    adv_reg <= wr_word;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state   <= ST_PREAMBLE;
                        pre_cnt <= 6'd0;
                    end
                endcase
            end
            // Rise and fall flags are mutually exclusive, so the tx_q shift never collides with the latch.
            if (mdc_fall) begin
                if (rd_act && state == ST_DATA) begin
                    mdio_t <= 1'b0;
                    mdio_o <= tx_q[15];
                    tx_q   <= {tx_q[14:0], 1'b0};
                end else if (rd_act && state == ST_TA && bit_cnt == 4'd1) begin
                    mdio_t <= 1'b0;
                    mdio_o <= 1'b0;
                end else begin
                    mdio_t <= 1'b1;
                    mdio_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder acting as a Clause 22 MDIO master.
module tb_mdio_responder;
    import mdio_pkg::*;

    localparam int H = 8;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        master_oe = 1'b1;
    logic        master_val = 1'b1;
    logic        link_up = 1'b0;
    logic        mdio_line;
    logic        mdio_o, mdio_t, wr_pulse;
    logic [15:0] ctrl_reg, adv_reg, wr_data;
    logic [4:0]  wr_addr;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] rd_exp_q[$];
    logic [20:0] wr_exp_q[$];
    logic [20:0] wr_obs_q[$];
    logic        drove_seen = 1'b0;

    assign mdio_line = master_oe ? master_val : (mdio_t ? 1'b1 : mdio_o);

    mdio_responder dut (
        .aclk     (aclk),
        .rst      (rst),
        .mdc_i    (mdc),
        .mdio_i   (mdio_line),
        .mdio_o   (mdio_o),
        .mdio_t   (mdio_t),
        .link_up  (link_up),
        .ctrl_reg (ctrl_reg),
        .adv_reg  (adv_reg),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (wr_pulse === 1'b1) wr_obs_q.push_back({wr_addr, wr_data});
        if (mdio_t === 1'b0) drove_seen = 1'b1;
    end

    task automatic half();
        repeat (H) @(negedge aclk);
    endtask

    task automatic send_bit(input logic v);
        master_oe = 1'b1;
        master_val = v;
        half();
        mdc = 1'b1;
        half();
        mdc = 1'b0;
    endtask

    task automatic recv_bit(output logic v);
        master_oe = 1'b0;
        half();
        v = mdio_line;
        mdc = 1'b1;
        half();
        mdc = 1'b0;
    endtask

    task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        for (int i = 0; i < pre; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 1; i >= 0; i--) send_bit(op[i]);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    endtask

    task automatic do_write(input int pre, input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd);
        send_header(pre, OP_WRITE, phy, ra);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 15; i >= 0; i--) send_bit(wd[i]);
        master_val = 1'b1;
        half();
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, output logic [15:0] rd, output logic ta2);
        logic b;
        send_header(32, OP_READ, phy, ra);
        recv_bit(b);
        recv_bit(ta2);
        for (int i = 15; i >= 0; i--) begin
            recv_bit(b);
            rd[i] = b;
        end
        half();
        master_oe = 1'b1;
        master_val = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL reset_mdio_t: got %b expected 1", mdio_t); end
        checks++; if (mdio_o !== 1'b0) begin errors++; $display("FAIL reset_mdio_o: got %b expected 0", mdio_o); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
        checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
        checks++; if (ctrl_reg !== 16'h3100) begin errors++; $display("FAIL reset_ctrl: got %h expected 3100", ctrl_reg); end
        checks++; if (adv_reg !== 16'h01E1) begin errors++; $display("FAIL reset_adv: got %h expected 01e1", adv_reg); end
        rst = 1'b0;
        repeat (4) @(negedge aclk);
    endtask

    task automatic test_read_id();
        logic [15:0] rd, exp;
        logic ta2;
        rd_exp_q.push_back(16'h0141);
        do_read(5'd1, REG_ID1, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (ta2 !== 1'b0) begin errors++; $display("FAIL read_id_ta2: got %b expected 0", ta2); end
        checks++; if (rd !== exp) begin errors++; $display("FAIL read_id_data: got %h expected %h", rd, exp); end
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL read_id_release: got %b expected 1", mdio_t); end
    endtask

    task automatic test_write_adv();
        logic [15:0] rd, exp;
        logic [20:0] wexp, wobs;
        logic ta2;
        wr_exp_q.push_back({REG_ADV, 16'h05E1});
        do_write(32, 5'd1, REG_ADV, 16'h05E1);
        checks++; if (adv_reg !== 16'h05E1) begin errors++; $display("FAIL write_adv_reg: got %h expected 05e1", adv_reg); end
        checks++; if (wr_obs_q.size() !== 1) begin errors++; $display("FAIL write_adv_pulses: got %0d expected 1", wr_obs_q.size()); end
        wexp = wr_exp_q.pop_front();
        wobs = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 21'h1FFFFF;
        wr_obs_q.delete();
        checks++; if (wobs !== wexp) begin errors++; $display("FAIL write_adv_event: got %h expected %h", wobs, wexp); end
        rd_exp_q.push_back(16'h05E1);
        do_read(5'd1, REG_ADV, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL write_adv_readback: got %h expected %h", rd, exp); end
    endtask

    task automatic test_wrong_phy();
        logic [15:0] rd;
        logic ta2;
        drove_seen = 1'b0;
        do_read(5'd2, REG_STAT, rd, ta2);
        checks++; if (drove_seen !== 1'b0) begin errors++; $display("FAIL wrong_phy_drive: got %b expected 0", drove_seen); end
        checks++; if (wr_obs_q.size() !== 0) begin errors++; $display("FAIL wrong_phy_pulse: got %0d expected 0", wr_obs_q.size()); end
        checks++; if (adv_reg !== 16'h05E1) begin errors++; $display("FAIL wrong_phy_adv: got %h expected 05e1", adv_reg); end
        wr_obs_q.delete();
    endtask

    task automatic test_short_preamble();
        do_write(31, 5'd1, REG_CTRL, 16'h1000);
        checks++; if (ctrl_reg !== 16'h3100) begin errors++; $display("FAIL short_pre_ctrl: got %h expected 3100", ctrl_reg); end
        checks++; if (wr_obs_q.size() !== 0) begin errors++; $display("FAIL short_pre_pulse: got %0d expected 0", wr_obs_q.size()); end
        wr_obs_q.delete();
    endtask

    task automatic test_soft_reset();
        logic [15:0] rd, exp;
        logic [20:0] wexp, wobs;
        logic ta2;
        wr_exp_q.push_back({REG_CTRL, 16'h8000});
        do_write(32, 5'd1, REG_CTRL, 16'h8000);
        checks++; if (ctrl_reg !== 16'h3100) begin errors++; $display("FAIL soft_rst_ctrl: got %h expected 3100", ctrl_reg); end
        checks++; if (adv_reg !== 16'h01E1) begin errors++; $display("FAIL soft_rst_adv: got %h expected 01e1", adv_reg); end
        wexp = wr_exp_q.pop_front();
        wobs = (wr_obs_q.size() == 1) ? wr_obs_q.pop_front() : 21'h1FFFFF;
        wr_obs_q.delete();
        checks++; if (wobs !== wexp) begin errors++; $display("FAIL soft_rst_event: got %h expected %h", wobs, wexp); end
        rd_exp_q.push_back(16'h3100);
        do_read(5'd1, REG_CTRL, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL soft_rst_readback: got %h expected %h", rd, exp); end
    endtask

    task automatic test_status_and_map();
        logic [15:0] rd, exp;
        logic [20:0] wexp, wobs;
        logic ta2;
        link_up = 1'b1;
        rd_exp_q.push_back(16'h780D);
        do_read(5'd1, REG_STAT, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL stat_link_up: got %h expected %h", rd, exp); end
        link_up = 1'b0;
        rd_exp_q.push_back(16'h7809);
        do_read(5'd1, REG_STAT, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL stat_link_down: got %h expected %h", rd, exp); end
        rd_exp_q.push_back(16'h0000);
        do_read(5'd1, 5'd7, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL unmapped_read: got %h expected %h", rd, exp); end
        wr_exp_q.push_back({5'd9, 16'h1234});
        do_write(32, 5'd1, 5'd9, 16'h1234);
        wexp = wr_exp_q.pop_front();
        wobs = (wr_obs_q.size() == 1) ? wr_obs_q.pop_front() : 21'h1FFFFF;
        wr_obs_q.delete();
        checks++; if (wobs !== wexp) begin errors++; $display("FAIL unmapped_write_event: got %h expected %h", wobs, wexp); end
        checks++; if ({ctrl_reg, adv_reg} !== {16'h3100, 16'h01E1}) begin errors++; $display("FAIL unmapped_write_regs: got %h expected 310001e1", {ctrl_reg, adv_reg}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd, exp;
        logic ta2;
        wr_exp_q.push_back({REG_CTRL, 16'h1140});
        do_write(32, 5'd1, REG_CTRL, 16'h1140);
        rd_exp_q.push_back(16'h1140);
        do_read(5'd1, REG_CTRL, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_ctrl_readback: got %h expected %h", rd, exp); end
        checks++; if (wr_obs_q.size() !== 1 || wr_obs_q[0] !== wr_exp_q[0]) begin errors++; $display("FAIL b2b_write_event: got %0d events expected 1 of %h", wr_obs_q.size(), wr_exp_q[0]); end
        wr_obs_q.delete();
        wr_exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rd, exp;
        logic b, ta2;
        send_header(32, OP_READ, 5'd1, REG_ID2);
        recv_bit(b);
        recv_bit(b);
        for (int i = 0; i < 7; i++) recv_bit(b);
        half();
        checks++; if (mdio_t !== 1'b0) begin errors++; $display("FAIL midframe_driving: got %b expected 0", mdio_t); end
        @(negedge aclk);
        rst = 1'b1;
        @(posedge aclk);
        #1;
        checks++; if (mdio_t !== 1'b1) begin errors++; $display("FAIL midframe_release: got %b expected 1", mdio_t); end
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        master_oe = 1'b1;
        master_val = 1'b1;
        repeat (4) @(negedge aclk);
        checks++; if (wr_obs_q.size() !== 0) begin errors++; $display("FAIL midframe_commit: got %0d expected 0", wr_obs_q.size()); end
        checks++; if (ctrl_reg !== 16'h3100) begin errors++; $display("FAIL midframe_ctrl: got %h expected 3100", ctrl_reg); end
        rd_exp_q.push_back(16'h0CC2);
        do_read(5'd1, REG_ID2, rd, ta2);
        exp = rd_exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL midframe_fresh_read: got %h expected %h", rd, exp); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_adv();
        test_wrong_phy();
        test_short_preamble();
        test_soft_reset();
        test_status_and_map();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
